// File: rtl/adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adder_pipe_pkg
// Shared definitions for the pipelined adder/subtractor:
//   - OP_ADD / OP_SUB : encodings of the i_sub mode input
//   - chunk_width()   : width of the slice handled by each pipeline stage
//   - signed_ovf()    : two's-complement overflow from operand/result MSBs
// -----------------------------------------------------------------------------
package adder_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Each stage resolves an equal slice of the carry chain.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Overflow: both addends share a sign and the result sign differs.
  // b_msb is the MSB of the operand actually added (already inverted for sub).
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_flex.sv
// -----------------------------------------------------------------------------
// adder_flex
// Combinational WIDTH-bit adder with carry in/out; used as the per-stage
// chunk adder of adder_pipe.
// Ports:
//   a_i, b_i [WIDTH] : addends
//   cin_i            : carry in
//   s_o [WIDTH]      : sum
//   cout_o           : carry out of the MSB
// -----------------------------------------------------------------------------
module adder_flex #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
// Pipelined add/subtract of WIDTH-bit operands. The carry chain is cut into
// STAGES chunks of CW = WIDTH/STAGES bits; stage k adds chunk k using the
// carry registered by stage k-1. Latency is STAGES cycles, throughput one
// operation per cycle, with valid/ready handshakes and full backpressure.
//
// Ports:
//   i_clk, i_rst      : clock (rising edge), synchronous active-high reset
//   i_valid / o_ready : upstream handshake (accept on i_valid && o_ready)
//   i_a, i_b [WIDTH]  : operands
//   i_cin             : carry-in (add) / borrow-in (sub)
//   i_sub             : 0 = add, 1 = subtract
//   o_valid / i_ready : downstream handshake
//   o_s [WIDTH]       : result
//   o_cout            : raw carry out of MSB (sub: 1 = no borrow)
//   o_ovf             : signed overflow
//   o_busy            : some stage holds a valid operation
//
// Optional build macro ADDER_PIPE_SAT_EN: on overflow o_s saturates to the
// signed max/min instead of wrapping; o_ovf and o_cout are unaffected.
// -----------------------------------------------------------------------------
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  // Stage registers. Operands travel with the partial sum so later stages
  // can add their chunk; the last stage's registers are the outputs.
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic              ovf_q;

  // Inputs seen by each stage (from upstream for stage 0, else stage k-1).
  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_c;
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [WIDTH-1:0]  stg_s [STAGES];

  logic [CW-1:0]     chunk_sum  [STAGES];
  logic              chunk_cout [STAGES];

  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_d;
  logic [STAGES-1:0] load;

  // Select each stage's inputs; subtraction is folded in at the entry by
  // inverting B and the carry-in so every stage is a plain adder.
  always_comb begin
    stg_vld[0] = i_valid;
    stg_a[0]   = i_a;
    stg_s[0]   = '0;
    if (i_sub == OP_SUB) begin
      stg_b[0] = ~i_b;
      stg_c[0] = ~i_cin;
    end else begin
      stg_b[0] = i_b;
      stg_c[0] = i_cin;
    end
    for (int k = 1; k < STAGES; k++) begin
      stg_vld[k] = vld_q[k-1];
      stg_a[k]   = a_q[k-1];
      stg_b[k]   = b_q[k-1];
      stg_s[k]   = s_q[k-1];
      stg_c[k]   = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    adder_flex #(
      .WIDTH(CW)
    ) u_adder (
      .a_i    (stg_a[k][k*CW +: CW]),
      .b_i    (stg_b[k][k*CW +: CW]),
      .cin_i  (stg_c[k]),
      .s_o    (chunk_sum[k]),
      .cout_o (chunk_cout[k])
    );
  end

  // Merge each new chunk into the partial sum; final-stage overflow/saturation.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = stg_s[k];
      s_d[k][k*CW +: CW] = chunk_sum[k];
    end
    ovf_d = signed_ovf(stg_a[LAST][MSB], stg_b[LAST][MSB], s_d[LAST][MSB]);
`ifdef ADDER_PIPE_SAT_EN
    // Operands share a sign on overflow: positive operands clip to max.
    if (ovf_d) begin
      if (stg_a[LAST][MSB]) begin
        s_d[LAST] = {1'b1, {MSB{1'b0}}};
      end else begin
        s_d[LAST] = {1'b0, {MSB{1'b1}}};
      end
    end else begin
      s_d[LAST] = s_d[LAST];
    end
`endif
  end

  // A stage may load when empty or when its content leaves this cycle;
  // evaluated from the output backwards so a drain ripples to the input.
  always_comb begin
    load       = '0;
    load[LAST] = !vld_q[LAST] || i_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      load[k] = !vld_q[k] || load[k+1];
    end
  end

  // Stage registers, each advancing only when it is allowed to load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= stg_vld[k];
          a_q[k]   <= stg_a[k];
          b_q[k]   <= stg_b[k];
          s_q[k]   <= s_d[k];
          c_q[k]   <= chunk_cout[k];
        end
      end
      if (load[LAST]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign o_ready = load[0] && !i_rst;
  assign o_valid = vld_q[LAST];
  assign o_s     = s_q[LAST];
  assign o_cout  = c_q[LAST];
  assign o_ovf   = ovf_q;
  assign o_busy  = |vld_q;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
// Three instances of adder_pipe (STAGES = 4, 1, 2; WIDTH = 32) share a clock
// and reset. Directed tests use the 4-stage instance; the random test runs
// on each instance in turn against a reference model.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

  localparam int W = 32;
  localparam int ND = 3;

  logic          clk;
  logic          rst;
  logic          vld_i [ND];
  logic          rdy_o [ND];
  logic [W-1:0]  a_i   [ND];
  logic [W-1:0]  b_i   [ND];
  logic          cin_i [ND];
  logic          sub_i [ND];
  logic          vld_o [ND];
  logic          rdy_i [ND];
  logic [W-1:0]  s_o   [ND];
  logic          cout_o[ND];
  logic          ovf_o [ND];
  logic          busy_o[ND];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    adder_pipe #(
      .WIDTH (W),
      .STAGES((d == 0) ? 4 : ((d == 1) ? 1 : 2))
    ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_valid(vld_i[d]),
      .o_ready(rdy_o[d]),
      .i_a    (a_i[d]),
      .i_b    (b_i[d]),
      .i_cin  (cin_i[d]),
      .i_sub  (sub_i[d]),
      .o_valid(vld_o[d]),
      .i_ready(rdy_i[d]),
      .o_s    (s_o[d]),
      .o_cout (cout_o[d]),
      .o_ovf  (ovf_o[d]),
      .o_busy (busy_o[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1);
  end

  // Reference: integer arithmetic on the true operation, returns {ovf,cout,s}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] raw;
    longint      sv;
    logic        cout;
    logic        ovf;
    logic [31:0] s;
    if (sub) begin
      raw  = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      cout = ~raw[32];
      sv   = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end else begin
      raw  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      cout = raw[32];
      sv   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    s   = raw[31:0];
`ifdef ADDER_PIPE_SAT_EN
    if (ovf) s = (sv > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {ovf, cout, s};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // One operation through instance 0 with i_ready high; returns the result
  // and the number of cycles from acceptance to o_valid.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          output logic [31:0] s, output logic cout,
                          output logic ovf, output int lat);
    int guard;
    @(negedge clk);
    a_i[0] = a; b_i[0] = b; cin_i[0] = cin; sub_i[0] = sub;
    vld_i[0] = 1'b1; rdy_i[0] = 1'b1;
    #1;
    guard = 0;
    while (!rdy_o[0] && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) vld_i[0] = 1'b0;
    end while (!vld_o[0] && lat < 50);
    s = s_o[0]; cout = cout_o[0]; ovf = ovf_o[0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (vld_o[0] !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", vld_o[0]); end
    n_cmp++; if (s_o[0] !== 32'h0) begin n_err++; $display("FAIL reset_s: got %h expected 0", s_o[0]); end
    n_cmp++; if (cout_o[0] !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout_o[0]); end
    n_cmp++; if (ovf_o[0] !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf_o[0]); end
    n_cmp++; if (busy_o[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o[0]); end
    n_cmp++; if (rdy_o[0] !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", rdy_o[0]); end
    rst = 1'b0;
    #1;
    n_cmp++; if (rdy_o[0] !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b expected 1", rdy_o[0]); end
  endtask

  task automatic test_add_carry();
    logic [31:0] s; logic c, v; int lat;
    send_one(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, s, c, v, lat);
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL add_latency: got %0d expected 4", lat); end
    n_cmp++; if (s !== 32'h0) begin n_err++; $display("FAIL add_carry_s: got %h expected 00000000", s); end
    n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL add_carry_cout: got %b expected 1", c); end
    n_cmp++; if (v !== 1'b0) begin n_err++; $display("FAIL add_carry_ovf: got %b expected 0", v); end
  endtask

  task automatic test_sub();
    logic [31:0] s; logic c, v; int lat;
    send_one(32'd5, 32'd7, 1'b0, 1'b1, s, c, v, lat);
    n_cmp++; if (s !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_5_7_s: got %h expected fffffffe", s); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL sub_5_7_cout: got %b expected 0", c); end
    n_cmp++; if (v !== 1'b0) begin n_err++; $display("FAIL sub_5_7_ovf: got %b expected 0", v); end
    send_one(32'd7, 32'd5, 1'b1, 1'b1, s, c, v, lat);
    n_cmp++; if (s !== 32'h1) begin n_err++; $display("FAIL sub_7_5_s: got %h expected 00000001", s); end
    n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL sub_7_5_cout: got %b expected 1", c); end
  endtask

  task automatic test_overflow();
    logic [31:0] s; logic c, v; int lat;
    logic [31:0] exp_pos, exp_neg;
`ifdef ADDER_PIPE_SAT_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h8000_0000; exp_neg = 32'h7FFF_FFFF;
`endif
    send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, v, lat);
    n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL pos_ovf_flag: got %b expected 1", v); end
    n_cmp++; if (s !== exp_pos) begin n_err++; $display("FAIL pos_ovf_s: got %h expected %h", s, exp_pos); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL pos_ovf_cout: got %b expected 0", c); end
    send_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, s, c, v, lat);
    n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL neg_ovf_flag: got %b expected 1", v); end
    n_cmp++; if (s !== exp_neg) begin n_err++; $display("FAIL neg_ovf_s: got %h expected %h", s, exp_neg); end
    n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL neg_ovf_cout: got %b expected 1", c); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] q[$];
    logic [33:0] exp, prev;
    int sent, got, first, last;
    logic saw_block, stall_prev;
    sent = 0; got = 0; first = -1; last = -1; saw_block = 1'b0; stall_prev = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        n_cmp++;
        if ({ovf_o[0], cout_o[0], s_o[0]} !== prev) begin
          n_err++; $display("FAIL stall_hold: got %h expected %h", {ovf_o[0], cout_o[0], s_o[0]}, prev);
        end
      end
      rdy_i[0] = !(cyc >= 4 && cyc < 10);
      if (sent < 8) begin
        a_i[0] = 32'h0123_4567 * 32'(sent + 1);
        b_i[0] = 32'h89AB_CDEF ^ a_i[0];
        cin_i[0] = sent[1];
        sub_i[0] = sent[0];
        vld_i[0] = 1'b1;
      end else begin
        vld_i[0] = 1'b0;
      end
      #1;
      if (vld_i[0] && !rdy_o[0]) saw_block = 1'b1;
      if (vld_i[0] && rdy_o[0]) begin
        q.push_back(model(a_i[0], b_i[0], cin_i[0], sub_i[0]));
        sent++;
      end
      if (vld_o[0] && rdy_i[0]) begin
        exp = (q.size() > 0) ? q.pop_front() : 34'h3_DEAD_BEEF;
        n_cmp++;
        if ({ovf_o[0], cout_o[0], s_o[0]} !== exp) begin
          n_err++; $display("FAIL b2b_result_%0d: got %h expected %h", got, {ovf_o[0], cout_o[0], s_o[0]}, exp);
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      stall_prev = vld_o[0] && !rdy_i[0];
      prev = {ovf_o[0], cout_o[0], s_o[0]};
    end
    vld_i[0] = 1'b0; rdy_i[0] = 1'b1;
    n_cmp++; if (saw_block !== 1'b1) begin n_err++; $display("FAIL b2b_ready_fell: got %b expected 1", saw_block); end
    n_cmp++; if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d expected 8", got); end
    n_cmp++; if (last - first != 7) begin n_err++; $display("FAIL b2b_throughput: got span %0d expected 7", last - first); end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL b2b_leftover: got %0d expected 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic c, v; int lat, stale;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_i[0] = 32'(i + 100); b_i[0] = 32'd1; cin_i[0] = 1'b0; sub_i[0] = 1'b0;
      vld_i[0] = 1'b1; rdy_i[0] = 1'b1;
    end
    @(negedge clk);
    vld_i[0] = 1'b0;
    #1;
    n_cmp++; if (busy_o[0] !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy_o[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (vld_o[0] !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: got %b expected 0", vld_o[0]); end
    n_cmp++; if (busy_o[0] !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b expected 0", busy_o[0]); end
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (vld_o[0]) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL mid_reset_stale: got %0d expected 0", stale); end
    send_one(32'h10, 32'h20, 1'b0, 1'b0, s, c, v, lat);
    n_cmp++; if (s !== 32'h30) begin n_err++; $display("FAIL after_reset_s: got %h expected 00000030", s); end
  endtask

  task automatic test_random(input int d, input int nops);
    logic [33:0] q[$];
    logic [33:0] exp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while ((sent < nops || got < sent) && cyc < nops * 12) begin
      @(negedge clk);
      cyc++;
      rdy_i[d] = ($urandom_range(0, 3) != 0);
      if (sent < nops && $urandom_range(0, 3) != 0) begin
        a_i[d] = pick(); b_i[d] = pick();
        cin_i[d] = 1'($urandom_range(0, 1));
        sub_i[d] = 1'($urandom_range(0, 1));
        vld_i[d] = 1'b1;
      end else begin
        vld_i[d] = 1'b0;
      end
      #1;
      if (vld_i[d] && rdy_o[d]) begin
        q.push_back(model(a_i[d], b_i[d], cin_i[d], sub_i[d]));
        sent++;
      end
      if (vld_o[d] && rdy_i[d]) begin
        exp = (q.size() > 0) ? q.pop_front() : 34'h3_DEAD_BEEF;
        n_cmp++;
        if ({ovf_o[d], cout_o[d], s_o[d]} !== exp) begin
          n_err++; $display("FAIL rand_dut%0d_op%0d: got %h expected %h", d, got, {ovf_o[d], cout_o[d], s_o[d]}, exp);
        end
        got++;
      end
    end
    vld_i[d] = 1'b0; rdy_i[d] = 1'b1;
    n_cmp++; if (got != nops) begin n_err++; $display("FAIL rand_dut%0d_count: got %0d expected %0d", d, got, nops); end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      vld_i[d] = 1'b0; rdy_i[d] = 1'b1; a_i[d] = '0; b_i[d] = '0;
      cin_i[d] = 1'b0; sub_i[d] = 1'b0;
    end
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    for (int d = 0; d < ND; d++) test_random(d, 2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Pipelined, parametrised successor to the combinational adder_flex: add/subtract of WIDTH-bit operands, carry chain split across STAGES register stages.
- Valid/ready handshake on both sides, full backpressure, one operation per cycle throughput.
- Sits between operand-fetch logic and result consumers, for wide datapaths where a single-cycle ripple carry misses timing.

Parameters:
- WIDTH, 32, operand/result width; must be divisible by STAGES (elaboration error otherwise).
- STAGES, 4, number of pipeline stages = chunks; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
- i_clk  input  1  clock, all logic rising-edge.
- i_rst  input  1  synchronous active-high reset.
- i_valid  input  1  upstream operation valid.
- o_ready  output  1  block can accept an operation this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in (add) / borrow-in (sub).
- i_sub  input  1  0 = add, 1 = subtract.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_s  output  WIDTH  result.
- o_cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
- o_ovf  output  1  signed two's-complement overflow.
- o_busy  output  1  any stage holds a valid operation.

Behaviour:
- Reset values: o_valid=0, o_s=0, o_cout=0, o_ovf=0, o_busy=0, all stage valids=0. o_ready=0 while i_rst=1.
- Arithmetic:
  - add: {o_cout,o_s} = i_a + i_b + i_cin.
  - sub: i_a + ~i_b + ~i_cin, i.e. i_a - i_b - i_cin.
  - o_ovf = (A[MSB]==B'[MSB]) && (o_s[MSB]!=A[MSB]), where B' = i_b in add mode, ~i_b in sub mode.
- Acceptance: an operation is accepted when i_valid && o_ready at a rising edge.
- Stage k (0..STAGES-1):
  - computes chunk k with a CW-bit adder using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - registers that sum chunk plus the unprocessed operand chunks.
- Latency: exactly STAGES cycles from acceptance to o_valid, with no stall.
- Stall rule:
  - stage k loads when it is empty, or when its content moves to stage k+1 (or out, for the last stage: i_ready && o_valid) in the same cycle.
  - o_ready = !stage0_valid || stage0_advances; combinational from i_ready, no bubble inserted.
- Hold: while o_valid && !i_ready, o_s/o_cout/o_ovf are stable.
- Ordering: no drop, duplication or reordering under any i_ready pattern.
- Simultaneous accept and drain on a full pipe: both occur, occupancy unchanged.
- Reset mid-operation: all in-flight operations are discarded; o_valid=0 from the cycle after i_rst is sampled high; none emerge afterwards.
- i_a/i_b/i_cin/i_sub are don't-care when not accepted.
- STAGES=1: single registered adder, latency 1.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined: when the final-stage result overflows, o_s saturates to signed max (0x7FF..F) on positive overflow or signed min (0x800..0) on negative overflow. o_ovf still asserts; o_cout is unchanged (raw).
- Undefined: o_s wraps modulo 2^WIDTH; no saturation logic is generated.

Decomposition:
- Package adder_pipe_pkg holds:
  - op-mode constants OP_ADD=1'b0, OP_SUB=1'b1.
  - function for chunk-width computation.
  - function for signed overflow detection.
- Sub-module: the existing adder_flex, instantiated per stage with WIDTH=CW, as the chunk adder; stage registers live in adder_pipe.

Test Plan:
- WIDTH=32, STAGES=4, reset, single add 0x0000_0001 + 0xFFFF_FFFF, cin=0 -> o_valid exactly 4 cycles after accept; o_s=0, o_cout=1, o_ovf=0 (carry crosses all chunks).
- Sub 5 - 7, cin=0 -> o_s=0xFFFF_FFFE, o_cout=0, o_ovf=0. Sub 7 - 5, cin=1 -> o_s=1, o_cout=1.
- Add 0x7FFF_FFFF + 1 -> o_ovf=1. Without macro o_s=0x8000_0000; with ADDER_PIPE_SAT_EN o_s=0x7FFF_FFFF. Add 0x8000_0000 + 0xFFFF_FFFF with macro -> o_s=0x8000_0000, o_ovf=1.
- 8 back-to-back ops, i_ready held low 6 cycles mid-stream:
  - o_ready falls once 4 stages are full.
  - o_s stable while stalled.
  - all 8 results in order, none lost or duplicated; full throughput after release.
- 3 ops in flight, i_rst pulsed 1 cycle -> o_valid=0 next cycle, o_busy=0; no stale result ever appears; a new op after reset completes normally.
- 2000 random ops (random i_sub, i_cin, i_valid, i_ready; includes all-ones/zero corners) vs scoreboard model -> zero mismatches; repeat with STAGES=1 and STAGES=2.
